// File: rtl/i2s_tx_64x.sv
// I2S transmitter, 64 bclk per frame (32-bit slots), one-bclk data delay after lrclk edge.
// One-pair holding register in front of a per-frame sample pair that is loaded at slot 0.
module i2s_tx_64x #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  bclk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] left_in,
    input  logic [DATA_WIDTH-1:0] right_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  lrclk,
    output logic                  sdout,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    logic [CNT_W-1:0]      p;
    logic [CNT_W-1:0]      p_next;
    logic                  full;
    logic [DATA_WIDTH-1:0] hold_l;
    logic [DATA_WIDTH-1:0] hold_r;
    logic [DATA_WIDTH-1:0] frame_l;
    logic [DATA_WIDTH-1:0] frame_r;
    logic                  load;
    logic                  xfer;
    logic                  sd_c;
    int unsigned           slot_j;
    logic [IDX_W-1:0]      bit_idx;

    assign p_next   = p + CNT_W'(1);
    assign load     = (p == CNT_W'(63));
    assign xfer     = in_valid & ~full;
    assign in_ready = ~full;

    // Serial bit for the period being entered; j = 0 and j > DATA_WIDTH pad with zero.
    always_comb begin
        sd_c    = 1'b0;
        slot_j  = 32'(p_next[4:0]);
        bit_idx = '0;
        if (slot_j >= 32'd1 && slot_j <= 32'(DATA_WIDTH)) begin
            bit_idx = IDX_W'(32'(DATA_WIDTH) - slot_j);
            sd_c    = p_next[5] ? frame_r[bit_idx] : frame_l[bit_idx];
        end
    end

    always_ff @(posedge bclk) begin
        if (rst) begin
            p           <= CNT_W'(63);
            lrclk       <= 1'b0;
            sdout       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            full        <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            frame_l     <= '0;
            frame_r     <= '0;
        end else begin
            p           <= p_next;
            lrclk       <= ~p_next[5];
            sdout       <= sd_c;
            frame_start <= load;
            underrun    <= load & ~full;
            if (load) begin
                if (full) begin
                    frame_l <= hold_l;
                    frame_r <= hold_r;
                    full    <= 1'b0;
                end else begin
                    frame_l <= '0;
                    frame_r <= '0;
                end
            end
            // Transfer only happens while empty, so it never collides with the load clear.
            if (xfer) begin
                hold_l <= left_in;
                hold_r <= right_in;
                full   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_64x.sv
// Bench for i2s_tx_64x: frame-level reference model plus a serial decoder that
// reassembles each frame's words from sdout and matches them to accepted pairs.
module tb_i2s_tx_64x;

    localparam int DW = 16;

    logic          bclk = 1'b0;
    logic          rst;
    logic [DW-1:0] left_in;
    logic [DW-1:0] right_in;
    logic          in_valid;
    logic          in_ready;
    logic          lrclk;
    logic          sdout;
    logic          frame_start;
    logic          underrun;

    i2s_tx_64x #(.DATA_WIDTH(DW)) dut (
        .bclk        (bclk),
        .rst         (rst),
        .left_in     (left_in),
        .right_in    (right_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .lrclk       (lrclk),
        .sdout       (sdout),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 bclk = ~bclk;

    int total = 0;
    int bad   = 0;

    // Reference state: period number, holding flag/pair, frame pair.
    int            mp;
    bit            mfull;
    logic [DW-1:0] mhl, mhr, mfl, mfr;
    bit            e_lr, e_sd, e_fs, e_ur;

    // Decoder state.
    logic [2*DW-1:0] exp_q[$];
    logic [2*DW-1:0] cur_exp;
    logic [DW-1:0]   dec_l, dec_r;
    bit              frame_ok;
    int              accepted_in_frame;
    bit              check_one_per_frame;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t p=%0d got=%h exp=%h", tag, $time, mp, got, exp);
        end
    endtask

    // Advance one bclk: model consumes the inputs seen at the edge, then DUT outputs are compared.
    task automatic cycle();
        bit xfer;
        int j;
        logic [DW-1:0] s;
        @(posedge bclk);
        if (rst) begin
            mp = 63; mfull = 0; mfl = '0; mfr = '0;
            e_lr = 0; e_sd = 0; e_fs = 0; e_ur = 0;
            exp_q.delete(); frame_ok = 0;
        end else begin
            xfer = in_valid && !mfull;
            mp   = (mp + 1) % 64;
            e_ur = 0;
            if (mp == 0) begin
                if (mfull) begin mfl = mhl; mfr = mhr; mfull = 0; end
                else begin mfl = '0; mfr = '0; e_ur = 1; end
                cur_exp = (!e_ur && exp_q.size() > 0) ? exp_q.pop_front() : '0;
                if (check_one_per_frame && frame_ok) check("one_per_frame", 32'(accepted_in_frame), 32'd1);
                frame_ok = 1; dec_l = '0; dec_r = '0; accepted_in_frame = 0;
            end
            if (xfer) begin
                mhl = left_in; mhr = right_in; mfull = 1;
                exp_q.push_back({left_in, right_in});
                accepted_in_frame++;
            end
            e_lr = (mp < 32);
            e_fs = (mp == 0);
            j    = mp % 32;
            s    = (mp < 32) ? mfl : mfr;
            e_sd = (j >= 1 && j <= DW) ? s[DW - j] : 1'b0;
        end
        #1;
        check("lrclk", 32'(lrclk), 32'(e_lr));
        check("sdout", 32'(sdout), 32'(e_sd));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("underrun", 32'(underrun), 32'(e_ur));
        check("in_ready", 32'(in_ready), 32'(!mfull));
        if (!rst && frame_ok) begin
            if (mp >= 1 && mp <= DW) dec_l = {dec_l[DW-2:0], sdout};
            if (mp >= 33 && mp <= 32 + DW) dec_r = {dec_r[DW-2:0], sdout};
            if (mp == 63) check("decoded_pair", 32'({dec_l, dec_r}), 32'(cur_exp));
        end
        @(negedge bclk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Bounded wait until the model is in period k (sitting at the negedge of that period).
    task automatic wait_period(input int k);
        int n = 0;
        while (mp != k && n < 200) begin cycle(); n++; end
        if (mp != k) check("wait_timeout", 32'(mp), 32'(k));
    endtask

    initial begin
        rst = 1; in_valid = 0; left_in = '0; right_in = '0;
        mp = 63; mfull = 0; mhl = '0; mhr = '0; mfl = '0; mfr = '0;
        cur_exp = '0; dec_l = '0; dec_r = '0; frame_ok = 0;
        accepted_in_frame = 0; check_one_per_frame = 0;
        @(negedge bclk);
        run(3);

        // Idle after reset: every frame underruns, all-zero data.
        rst = 0;
        run(128);

        // Known pair accepted during period 10.
        wait_period(10);
        left_in = 16'hA5C3; right_in = 16'h1234; in_valid = 1;
        cycle();
        in_valid = 0;
        run(140);

        // Continuous valid with back-to-back pairs, including extremes.
        wait_period(5);
        check_one_per_frame = 1;
        in_valid = 1;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: begin left_in = 16'h8000; right_in = 16'h7FFF; end
                1: begin left_in = 16'hFFFF; right_in = 16'h0000; end
                default: begin left_in = 16'($urandom); right_in = 16'($urandom); end
            endcase
            run(64);
        end
        in_valid = 0;
        run(64);
        check_one_per_frame = 0;

        // Pair offered only on the edge entering period 0 while empty.
        wait_period(63);
        left_in = 16'h5A5A; right_in = 16'hC3C3; in_valid = 1;
        cycle();
        check("late_pair_underrun", 32'(underrun), 32'd1);
        in_valid = 0;
        run(130);

        // Reset at period 40 with a held pair: the pair must be discarded.
        wait_period(2);
        left_in = 16'hDEAD; right_in = 16'hBEEF; in_valid = 1;
        cycle();
        in_valid = 0;
        wait_period(40);
        rst = 1;
        cycle();
        rst = 0;
        run(130);

        // Random traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            in_valid = ($urandom_range(0, 99) < 4);
            left_in  = 16'($urandom);
            right_in = 16'($urandom);
            rst      = ($urandom_range(0, 999) == 0);
            cycle();
        end
        rst = 0; in_valid = 0;
        run(64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
